// File: rtl/axil_arbiter_rd.sv
// axil_arbiter_rd
// Read-channel arbiter/sequencer for the AXI-Lite priority interconnect.
// Grants one master the AR path, waits out the registered address decoder,
// then either routes AR/R to the decoded slave or answers DECERR itself.
// One outstanding read at a time; the grant is held until the R handshake.
//
// Build option:
//   AXIL_ARB_RD_RR_EN  defined   -> round-robin arbitration (rr_ptr register)
//                      undefined -> fixed priority, lowest index wins
module axil_arbiter_rd #(
   parameter int NUMBER_MASTER = 4,
   parameter int NUMBER_SLAVE  = 4,
   parameter int DECODE_CYCLES = 2,
   localparam int IDX_W = (NUMBER_MASTER > 1) ? $clog2(NUMBER_MASTER) : 1
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUMBER_MASTER-1:0] m_arvalid,
   output logic [NUMBER_MASTER-1:0] grant,
   output logic [IDX_W-1:0]         grant_idx,
   output logic                     dec_arvalid,
   input  logic [NUMBER_SLAVE-1:0]  slv_valid,
   input  logic                     slv_invalid,
   output logic [NUMBER_SLAVE-1:0]  slv_sel,
   output logic                     ar_en,
   input  logic                     ar_hs,
   input  logic                     r_hs,
   output logic                     err_rvalid,
   input  logic                     err_rready,
   output logic                     busy
);

   localparam int                CNT_W    = (DECODE_CYCLES > 1) ? $clog2(DECODE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECODE_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUMBER_MASTER - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_ADDR,
      S_RESP,
      S_ERR
   } state_t;

   state_t                   state;
   state_t                   state_nxt;
   logic [CNT_W-1:0]         cnt;
   logic                     req_any;
   logic                     dec_last;
   logic                     dec_hit;
   logic [NUMBER_SLAVE-1:0]  slv_low;
   logic [IDX_W-1:0]         win_idx;
   logic                     win_found;
   logic [NUMBER_MASTER-1:0] win_oh;

   assign req_any  = |m_arvalid;
   assign dec_last = (state == S_DECODE) && (cnt == CNT_LAST);
   assign dec_hit  = !slv_invalid && (|slv_valid);
   assign win_oh   = NUMBER_MASTER'(1) << win_idx;

   // keep only the lowest set decoder hit (overlapping ranges go to the lowest slave)
   always_comb begin
      slv_low = '0;
      for (int unsigned i = 0; i < NUMBER_SLAVE; i++) begin
         if (slv_valid[i] && (slv_low == '0)) begin
            slv_low[i] = 1'b1;
         end
      end
   end

`ifdef AXIL_ARB_RD_RR_EN
   logic [IDX_W-1:0] rr_ptr;

   // round-robin winner: first requester at or after rr_ptr, wrapping
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int unsigned i = 0; i < NUMBER_MASTER; i++) begin
         if (!win_found && m_arvalid[(int'(rr_ptr) + i) % NUMBER_MASTER]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'((int'(rr_ptr) + i) % NUMBER_MASTER);
         end
      end
   end

   // pointer moves to the master after the one just granted
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rr_ptr <= '0;
      end else if ((state == S_IDLE) && req_any) begin
         rr_ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + IDX_W'(1);
      end
   end
`else
   // fixed-priority winner: lowest requesting index
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int unsigned i = 0; i < NUMBER_MASTER; i++) begin
         if (!win_found && m_arvalid[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end
`endif

   // state register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (req_any)    state_nxt = S_DECODE;
         S_DECODE: if (dec_last)   state_nxt = dec_hit ? S_ADDR : S_ERR;
         S_ADDR:   if (ar_hs)      state_nxt = S_RESP;
         S_RESP:   if (r_hs)       state_nxt = S_IDLE;
         S_ERR:    if (err_rready) state_nxt = S_IDLE;
         default:                  state_nxt = S_IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      dec_arvalid = 1'b0;
      ar_en       = 1'b0;
      err_rvalid  = 1'b0;
      busy        = (state != S_IDLE);
      case (state)
         S_DECODE: dec_arvalid = 1'b1;
         S_ADDR:   ar_en       = 1'b1;
         S_ERR:    err_rvalid  = 1'b1;
         default:  ;
      endcase
   end

   // grant, decode counter and slave select registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         grant     <= '0;
         grant_idx <= '0;
         cnt       <= '0;
         slv_sel   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (req_any) begin
                  grant     <= win_oh;
                  grant_idx <= win_idx;
               end else begin
                  grant     <= '0;
                  grant_idx <= '0;
               end
            end
            S_DECODE: begin
               cnt <= cnt + CNT_W'(1);
               if (dec_last) begin
                  slv_sel <= slv_low;
               end
            end
            S_RESP: begin
               if (r_hs) begin
                  grant     <= '0;
                  grant_idx <= '0;
                  slv_sel   <= '0;
               end
            end
            S_ERR: begin
               if (err_rready) begin
                  grant     <= '0;
                  grant_idx <= '0;
                  slv_sel   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_arbiter_rd.sv
// tb_axil_arbiter_rd
// Directed scenarios plus randomized traffic against a transaction-level
// model of the read arbiter. Honours AXIL_ARB_RD_RR_EN like the design.
module tb_axil_arbiter_rd;

   localparam int NM = 4;
   localparam int NS = 4;
   localparam int DC = 2;
`ifdef AXIL_ARB_RD_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [NM-1:0] m_arvalid = '0;
   logic [NM-1:0] grant;
   logic [1:0]    grant_idx;
   logic          dec_arvalid;
   logic [NS-1:0] slv_valid = '0;
   logic          slv_invalid = 1'b0;
   logic [NS-1:0] slv_sel;
   logic          ar_en;
   logic          ar_hs = 1'b0;
   logic          r_hs = 1'b0;
   logic          err_rvalid;
   logic          err_rready = 1'b0;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 aclk = ~aclk;

   axil_arbiter_rd #(
      .NUMBER_MASTER(NM),
      .NUMBER_SLAVE (NS),
      .DECODE_CYCLES(DC)
   ) dut (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .m_arvalid  (m_arvalid),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .dec_arvalid(dec_arvalid),
      .slv_valid  (slv_valid),
      .slv_invalid(slv_invalid),
      .slv_sel    (slv_sel),
      .ar_en      (ar_en),
      .ar_hs      (ar_hs),
      .r_hs       (r_hs),
      .err_rvalid (err_rvalid),
      .err_rready (err_rready),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   // One open read at most: who holds it, how many cycles since the grant,
   // what the decoder said, and whether the address phase has completed.
   logic          md_act;
   int            md_idx;
   int            md_age;
   logic [NS-1:0] md_sel;
   logic          md_err;
   logic          md_adone;
   int            md_rr;

   function automatic int pick(input logic [NM-1:0] req, input int start);
      for (int k = 0; k < NM; k++) begin
         int j;
         j = (start + k) % NM;
         if (req[j]) return j;
      end
      return 0;
   endfunction

   function automatic logic [NS-1:0] lowbit(input logic [NS-1:0] v);
      return v & (~v + NS'(1));
   endfunction

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         md_act <= 1'b0; md_idx <= 0; md_age <= 0; md_sel <= '0;
         md_err <= 1'b0; md_adone <= 1'b0; md_rr <= 0;
      end else if (!md_act) begin
         if (m_arvalid != '0) begin
            md_act   <= 1'b1;
            md_idx   <= pick(m_arvalid, RR_EN ? md_rr : 0);
            md_rr    <= (pick(m_arvalid, RR_EN ? md_rr : 0) + 1) % NM;
            md_age   <= 1;
            md_adone <= 1'b0;
            md_err   <= 1'b0;
            md_sel   <= '0;
         end
      end else if (md_age <= DC) begin
         if (md_age == DC) begin
            md_sel <= lowbit(slv_valid);
            md_err <= slv_invalid || (slv_valid == '0);
         end
         md_age <= md_age + 1;
      end else if (md_err) begin
         if (err_rready) begin md_act <= 1'b0; md_sel <= '0; end
      end else if (!md_adone) begin
         if (ar_hs) md_adone <= 1'b1;
      end else if (r_hs) begin
         md_act <= 1'b0; md_sel <= '0;
      end
   end

   logic [NM-1:0] e_grant;
   logic [1:0]    e_gidx;
   logic          e_post;
   assign e_grant = md_act ? NM'(1 << md_idx) : '0;
   assign e_gidx  = md_act ? 2'(md_idx) : 2'b0;
   assign e_post  = md_act && (md_age > DC);

   // every-cycle comparison of all outputs against the model
   always @(negedge aclk) begin
      if (aresetn) begin
         chk("m_grant",       grant,       e_grant);
         chk("m_grant_idx",   grant_idx,   e_gidx);
         chk("m_dec_arvalid", dec_arvalid, md_act && (md_age <= DC));
         chk("m_ar_en",       ar_en,       e_post && !md_err && !md_adone);
         chk("m_err_rvalid",  err_rvalid,  e_post && md_err);
         chk("m_slv_sel",     slv_sel,     e_post ? md_sel : '0);
         chk("m_busy",        busy,        md_act);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic finish_txn();
      int t;
      t = 0;
      while (!ar_en && !err_rvalid && t < 20) begin @(negedge aclk); t++; end
      if (!ar_en && !err_rvalid) begin
         chk("wait_addr_or_err", busy, 0);
         return;
      end
      if (err_rvalid) begin
         err_rready = 1'b1; @(negedge aclk); err_rready = 1'b0;
      end else begin
         ar_hs = 1'b1; @(negedge aclk); ar_hs = 1'b0;
         r_hs  = 1'b1; @(negedge aclk); r_hs  = 1'b0;
      end
   endtask

   task automatic run_txn(input logic [NM-1:0] req, input logic [NS-1:0] sv,
                          input logic inv, output logic [NM-1:0] g);
      int t;
      m_arvalid = req; slv_valid = sv; slv_invalid = inv; g = '0;
      t = 0;
      while (!busy && t < 20) begin @(negedge aclk); t++; end
      if (!busy) begin
         chk("wait_busy", busy, 1);
         return;
      end
      g = grant;
      finish_txn();
   endtask

   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1);
   end

   initial begin
      logic [NM-1:0] g0, g1, g2;
      logic          seen;
      int            t;

      // reset state
      repeat (2) @(negedge aclk);
      chk("rst_grant", grant, 0);
      chk("rst_grant_idx", grant_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ar_en", ar_en, 0);
      chk("rst_slv_sel", slv_sel, 0);
      chk("rst_err_rvalid", err_rvalid, 0);
      chk("rst_dec_arvalid", dec_arvalid, 0);
      aresetn = 1'b1;
      @(negedge aclk);

      // single read from master 1, decoder hits slave 2
      m_arvalid = 4'b0010; slv_valid = 4'b0100; slv_invalid = 1'b0;
      @(negedge aclk);
      chk("t2_grant", grant, 4'b0010);
      chk("t2_model_grant", e_grant, 4'b0010);
      chk("t2_dec_arvalid", dec_arvalid, 1);
      @(negedge aclk);
      chk("t2_ar_en_c2", ar_en, 0);
      @(negedge aclk);
      chk("t2_ar_en_c3", ar_en, 1);
      chk("t2_slv_sel", slv_sel, 4'b0100);
      ar_hs = 1'b1; m_arvalid = '0;
      @(negedge aclk);
      ar_hs = 1'b0;
      chk("t2_resp_busy", busy, 1);
      r_hs = 1'b1;
      @(negedge aclk);
      r_hs = 1'b0;
      chk("t2_done_busy", busy, 0);
      chk("t2_done_grant", grant, 0);

      // 1010 held across three reads; fresh reset puts rr_ptr at 0
      aresetn = 1'b0; @(negedge aclk); aresetn = 1'b1; @(negedge aclk);
      run_txn(4'b1010, 4'b0001, 1'b0, g0);
      run_txn(4'b1010, 4'b0001, 1'b0, g1);
      run_txn(4'b1010, 4'b0001, 1'b0, g2);
      m_arvalid = '0;
      chk("t3_grant0", g0, 4'b0010);
      chk("t3_grant1", g1, RR_EN ? 4'b1000 : 4'b0010);
      chk("t3_grant2", g2, 4'b0010);
      @(negedge aclk);

      // decode miss answered with DECERR
      m_arvalid = 4'b1000; slv_valid = '0; slv_invalid = 1'b1; seen = 1'b0; t = 0;
      while (!err_rvalid && t < 20) begin
         @(negedge aclk);
         if (ar_en) seen = 1'b1;
         t++;
      end
      chk("t4_err_rvalid", err_rvalid, 1);
      chk("t4_ar_en", ar_en, 0);
      chk("t4_grant", grant, 4'b1000);
      m_arvalid = '0; err_rready = 1'b1;
      @(negedge aclk);
      err_rready = 1'b0; slv_invalid = 1'b0;
      chk("t4_busy_after", busy, 0);
      chk("t4_grant_after", grant, 0);
      chk("t4_ar_en_seen", seen, 0);
      @(negedge aclk);

      // asynchronous reset while in RESP
      m_arvalid = 4'b0001; slv_valid = 4'b0010; t = 0;
      while (!ar_en && t < 20) begin @(negedge aclk); t++; end
      chk("t5_ar_en", ar_en, 1);
      ar_hs = 1'b1; m_arvalid = '0;
      @(negedge aclk);
      ar_hs = 1'b0;
      chk("t5_resp_slv_sel", slv_sel, 4'b0010);
      chk("t5_resp_grant", grant, 4'b0001);
      @(posedge aclk);
      #2 aresetn = 1'b0;
      #1;
      chk("t5_async_grant", grant, 0);
      chk("t5_async_slv_sel", slv_sel, 0);
      chk("t5_async_err_rvalid", err_rvalid, 0);
      chk("t5_async_ar_en", ar_en, 0);
      chk("t5_async_busy", busy, 0);
      @(negedge aclk); @(negedge aclk);
      aresetn = 1'b1; m_arvalid = 4'b0001; slv_valid = 4'b0001;
      @(negedge aclk);
      chk("t5_regrant", grant, 4'b0001);
      m_arvalid = '0;
      finish_txn();
      @(negedge aclk);

      // r_hs and a new request in the same RESP cycle
      m_arvalid = 4'b0001; slv_valid = 4'b0001; t = 0;
      while (!ar_en && t < 20) begin @(negedge aclk); t++; end
      chk("t6_ar_en", ar_en, 1);
      ar_hs = 1'b1; m_arvalid = '0;
      @(negedge aclk);
      ar_hs = 1'b0; r_hs = 1'b1; m_arvalid = 4'b0100;
      @(negedge aclk);
      r_hs = 1'b0;
      chk("t6_gap_busy", busy, 0);
      chk("t6_gap_grant", grant, 0);
      @(negedge aclk);
      chk("t6_new_grant", grant, 4'b0100);
      m_arvalid = '0;
      finish_txn();
      @(negedge aclk);

      // randomized traffic, checked every cycle by the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge aclk);
         if ($urandom_range(0, 999) == 0) begin
            aresetn = 1'b0;
            @(negedge aclk);
            aresetn = 1'b1;
         end
         m_arvalid   = ($urandom_range(0, 3) == 0) ? '0 : NM'($urandom);
         slv_valid   = NS'($urandom);
         slv_invalid = ($urandom_range(0, 3) == 0);
         ar_hs       = ($urandom_range(0, 2) == 0);
         r_hs        = ($urandom_range(0, 2) == 0);
         err_rready  = ($urandom_range(0, 1) == 0);
      end
      @(negedge aclk);
      m_arvalid = '0; ar_hs = 1'b0; r_hs = 1'b0; err_rready = 1'b0;
      repeat (3) @(negedge aclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
